// File: rtl/ext_prog_loader.sv
// ---------------------------------------------------------------------------
// ext_prog_loader
//
// Host-side master for the CPU's external memory port. It takes a word stream
// and writes it into instruction memory at consecutive addresses. It can then
// read the image back and compare a modular checksum. Finally it holds the CPU
// execution enable high until it is aborted.
//
// Ports
//   clk         clock, all state on the rising edge
//   arst        asynchronous reset, active-high
//   start       begin a load (sampled only in IDLE)
//   num_words   word count, sampled with start
//   verify_en   readback check enable, sampled with start
//   abort       return to IDLE from any state
//   s_valid     stream word valid
//   s_data      stream word
//   s_ready     loader accepts s_data this cycle
//   addr_ext    memory address (registered)
//   wen_ext     memory write strobe (registered)
//   ren_ext     memory read strobe (registered)
//   wdata_ext   memory write data (registered)
//   rdata_ext   memory read data, valid RD_LAT cycles after ren_ext
//   cpu_enable  CPU execution enable (high in RUN)
//   busy        high in LOAD, VERIFY, DRAIN
//   done        high in RUN
//   error       high in ERROR
//   checksum    sum of the written words, mod 2^DATA_W
//   dbg_state   current FSM state encoding, for observation only
//
// Stream handshake: a word transfers on a rising edge where s_valid and
// s_ready are both high. s_ready never depends on s_valid. Once the producer
// raises s_valid, it holds s_valid and s_data until the transfer happens.
// ---------------------------------------------------------------------------
module ext_prog_loader #(
  parameter int                 ADDR_W     = 64,
  parameter int                 DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
  parameter int                 WORD_BYTES = 4,
  parameter int                 RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic [15:0]       num_words,
  input  logic              verify_en,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  input  logic [DATA_W-1:0] rdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_VERIFY = 3'd2,
    S_DRAIN  = 3'd3,
    S_RUN    = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]       r_num;
  logic              r_verify;
  logic [15:0]       r_idx;      // words accepted from the stream
  logic [15:0]       r_ridx;     // reads issued during VERIFY
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic              r_ren;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_checksum;
  logic [DATA_W-1:0] r_rsum;
  logic [RD_LAT-1:0] r_rd_pipe;  // bit k set: a read issued k+1 cycles after ren_ext

  logic              w_s_ready;
  logic              w_hs;
  logic              w_drained;
  logic [RD_LAT-1:0] w_pipe_next;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;

  // Address arithmetic wraps naturally mod 2^ADDR_W.
  assign w_wr_addr = BASE_ADDR + ADDR_W'(r_idx)  * STRIDE;
  assign w_rd_addr = BASE_ADDR + ADDR_W'(r_ridx) * STRIDE;
  assign w_hs      = s_valid && w_s_ready;

  // No read is still in flight: none is being presented and none is in the delay line.
  assign w_drained = !r_ren && (r_rd_pipe == '0);

  always_comb begin
    w_pipe_next    = r_rd_pipe << 1;
    w_pipe_next[0] = r_ren;
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_next = r_state;
    if (abort) begin
      // abort wins over everything, including a start in IDLE
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) w_next = (num_words != 16'd0) ? S_LOAD : S_RUN;
        end
        S_LOAD: begin
          // idx reaches num_words in the cycle of the final write pulse
          if (r_idx == r_num) w_next = r_verify ? S_VERIFY : S_RUN;
        end
        S_VERIFY: begin
          if (r_ridx == r_num - 16'd1) w_next = S_DRAIN;
        end
        S_DRAIN: begin
          if (w_drained) w_next = (r_rsum == r_checksum) ? S_RUN : S_ERROR;
        end
        S_RUN:   w_next = S_RUN;
        S_ERROR: w_next = S_ERROR;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // ---------------- output logic ----------------
  always_comb begin
    w_s_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_enable = 1'b0;
    case (r_state)
      S_LOAD: begin
        busy      = 1'b1;
        // closed during abort so no word is consumed and then dropped
        w_s_ready = (r_idx < r_num) && !abort;
      end
      S_VERIFY, S_DRAIN: busy = 1'b1;
      S_RUN: begin
        done       = 1'b1;
        cpu_enable = 1'b1;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign s_ready   = w_s_ready;
  assign addr_ext  = r_addr;
  assign wen_ext   = r_wen;
  assign ren_ext   = r_ren;
  assign wdata_ext = r_wdata;
  assign checksum  = r_checksum;
  assign dbg_state = r_state;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_num      <= '0;
      r_verify   <= 1'b0;
      r_idx      <= '0;
      r_ridx     <= '0;
      r_addr     <= '0;
      r_wen      <= 1'b0;
      r_ren      <= 1'b0;
      r_wdata    <= '0;
      r_checksum <= '0;
      r_rsum     <= '0;
      r_rd_pipe  <= '0;
    end else begin
      // strobes are single-cycle unless re-armed below
      r_wen <= 1'b0;
      r_ren <= 1'b0;

      // abort discards every read still in flight
      r_rd_pipe <= abort ? '0 : w_pipe_next;
      if (!abort && r_rd_pipe[RD_LAT-1]) r_rsum <= r_rsum + rdata_ext;

      case (r_state)
        S_IDLE: begin
          if (!abort && start && (num_words != 16'd0)) begin
            r_num      <= num_words;
            r_verify   <= verify_en;
            r_idx      <= '0;
            r_ridx     <= '0;
            r_checksum <= '0;
            r_rsum     <= '0;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            r_wen      <= 1'b1;
            r_addr     <= w_wr_addr;
            r_wdata    <= s_data;
            r_checksum <= r_checksum + s_data;
            r_idx      <= r_idx + 16'd1;
          end
        end
        S_VERIFY: begin
          if (!abort) begin
            r_ren  <= 1'b1;
            r_addr <= w_rd_addr;
            r_ridx <= r_ridx + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_prog_loader.sv
module tb_ext_prog_loader;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic          start, verify_en, abort, s_valid;
  logic [15:0]   num_words;
  logic [DW-1:0] s_data;
  logic [DW-1:0] rdata_ext;

  logic          s_ready, wen_ext, ren_ext, cpu_enable, busy, done, error;
  logic [AW-1:0] addr_ext;
  logic [DW-1:0] wdata_ext, checksum;
  logic [2:0]    dbg_state;

  logic          wr_s_ready, wr_wen, wr_ren, wr_cpu_enable, wr_busy, wr_done, wr_error;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_wdata, wr_checksum;
  logic [2:0]    wr_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // main DUT: base 0, two-cycle read latency
  ext_prog_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(64'h0), .WORD_BYTES(4), .RD_LAT(2)) u_dut (
    .clk(clk), .arst(arst), .start(start), .num_words(num_words), .verify_en(verify_en),
    .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .rdata_ext(rdata_ext), .cpu_enable(cpu_enable), .busy(busy), .done(done),
    .error(error), .checksum(checksum), .dbg_state(dbg_state)
  );

  // second DUT sharing the stimulus: base address just below the top of the space
  ext_prog_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(64'hFFFF_FFFF_FFFF_FFFC), .WORD_BYTES(4), .RD_LAT(1)) u_wrap (
    .clk(clk), .arst(arst), .start(start), .num_words(num_words), .verify_en(verify_en),
    .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(wr_s_ready),
    .addr_ext(wr_addr), .wen_ext(wr_wen), .ren_ext(wr_ren), .wdata_ext(wr_wdata),
    .rdata_ext(rdata_ext), .cpu_enable(wr_cpu_enable), .busy(wr_busy), .done(wr_done),
    .error(wr_error), .checksum(wr_checksum), .dbg_state(wr_dbg_state)
  );

  // ---------------- memory model (read latency 2) ----------------
  logic [DW-1:0] mem [0:15];
  logic [AW-1:0] rq0, rq1;
  logic          corrupt;

  always @(posedge clk) begin
    if (wen_ext) mem[addr_ext[5:2]] <= wdata_ext;
    rq0 <= addr_ext;
    rq1 <= rq0;
  end
  assign rdata_ext = (corrupt && rq1[5:2] == 4'd1) ? 32'h0000_0002 : mem[rq1[5:2]];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [15:0] n, input logic v);
    start     = 1'b1;
    num_words = n;
    verify_en = v;
    step();
    start     = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst = 1'b1;
    step();
    step();
    n_checks++; if (wen_ext !== 1'b0 || ren_ext !== 1'b0 || s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got wen=%b ren=%b rdy=%b expected 0 0 0", wen_ext, ren_ext, s_ready); end
    n_checks++; if (addr_ext !== 64'h0 || wdata_ext !== 32'h0 || checksum !== 32'h0) begin n_fail++; $display("FAIL reset_regs: got addr=%h wdata=%h cs=%h expected 0", addr_ext, wdata_ext, checksum); end
    n_checks++; if ({cpu_enable, busy, done, error} !== 4'b0000 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_status: got en/busy/done/err=%b state=%0d expected 0000 state 0", {cpu_enable, busy, done, error}, dbg_state); end
    #2 arst = 1'b0;
    step();
  endtask

  task automatic test_basic_load();
    logic [DW-1:0] data [3];
    logic [AW-1:0] addr [3];
    data = '{32'h11, 32'h22, 32'h33};
    addr = '{64'h0, 64'h4, 64'h8};
    start_load(16'd3, 1'b0);
    n_checks++; if (s_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got rdy=%b busy=%b expected 1 1", s_ready, busy); end
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = data[i];
      step();
      n_checks++; if (wen_ext !== 1'b1 || addr_ext !== addr[i] || wdata_ext !== data[i]) begin n_fail++; $display("FAIL basic_write%0d: got wen=%b addr=%h data=%h expected 1 %h %h", i, wen_ext, addr_ext, wdata_ext, addr[i], data[i]); end
    end
    s_valid = 1'b0;
    n_checks++; if (s_ready !== 1'b0 || cpu_enable !== 1'b0) begin n_fail++; $display("FAIL basic_last: got rdy=%b en=%b expected 0 0", s_ready, cpu_enable); end
    n_checks++; if (checksum !== 32'h66) begin n_fail++; $display("FAIL basic_checksum: got %h expected 66", checksum); end
    step();
    n_checks++; if (cpu_enable !== 1'b1 || done !== 1'b1 || wen_ext !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_run: got en=%b done=%b wen=%b busy=%b expected 1 1 0 0", cpu_enable, done, wen_ext, busy); end
    abort = 1'b1;
    start = 1'b1;
    num_words = 16'd5;
    step();
    abort = 1'b0;
    start = 1'b0;
    n_checks++; if (dbg_state !== ST_IDLE || cpu_enable !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL basic_abort: got state=%0d en=%b done=%b expected 0 0 0", dbg_state, cpu_enable, done); end
    n_checks++; if (checksum !== 32'h66) begin n_fail++; $display("FAIL basic_abort_cs: got %h expected 66", checksum); end
    step();
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_start_ignored: got state=%0d expected 0", dbg_state); end
  endtask

  task automatic test_gapped();
    int writes;
    writes = 0;
    start_load(16'd2, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'h0000_1000;
    step();
    if (wen_ext === 1'b1) writes++;
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wen_ext === 1'b1) writes++;
      n_checks++; if (wen_ext !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL gap_cycle%0d: got wen=%b rdy=%b expected 0 1", i, wen_ext, s_ready); end
    end
    s_valid = 1'b1;
    s_data  = 32'h0000_0234;
    step();
    if (wen_ext === 1'b1) writes++;
    n_checks++; if (addr_ext !== 64'h4 || s_ready !== 1'b0) begin n_fail++; $display("FAIL gap_second: got addr=%h rdy=%b expected 4 0", addr_ext, s_ready); end
    s_data = 32'hBAD0_BAD0;   // offered after the last word: must not be taken
    step();
    if (wen_ext === 1'b1) writes++;
    s_valid = 1'b0;
    n_checks++; if (writes != 2) begin n_fail++; $display("FAIL gap_write_count: got %0d expected 2", writes); end
    n_checks++; if (checksum !== 32'h0000_1234 || dbg_state !== ST_RUN) begin n_fail++; $display("FAIL gap_end: got cs=%h state=%0d expected 1234 4", checksum, dbg_state); end
    do_abort();
  endtask

  task automatic run_verify(input logic bad, input string tag);
    corrupt = bad;
    start_load(16'd2, 1'b1);
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    step();
    s_data  = 32'h0000_0001;
    step();
    s_valid = 1'b0;
    step();
    step();
    n_checks++; if (ren_ext !== 1'b1 || wen_ext !== 1'b0 || addr_ext !== 64'h0) begin n_fail++; $display("FAIL %s_read0: got ren=%b wen=%b addr=%h expected 1 0 0", tag, ren_ext, wen_ext, addr_ext); end
    step();
    n_checks++; if (ren_ext !== 1'b1 || wen_ext !== 1'b0 || addr_ext !== 64'h4) begin n_fail++; $display("FAIL %s_read1: got ren=%b wen=%b addr=%h expected 1 0 4", tag, ren_ext, wen_ext, addr_ext); end
    for (int i = 0; i < 20 && !(done === 1'b1 || error === 1'b1); i++) step();
  endtask

  task automatic test_verify_pass();
    run_verify(1'b0, "vpass");
    n_checks++; if (done !== 1'b1 || error !== 1'b0 || cpu_enable !== 1'b1) begin n_fail++; $display("FAIL vpass_end: got done=%b err=%b en=%b expected 1 0 1", done, error, cpu_enable); end
    n_checks++; if (checksum !== 32'hDEAD_BEF0) begin n_fail++; $display("FAIL vpass_checksum: got %h expected deadbef0", checksum); end
    do_abort();
  endtask

  task automatic test_verify_fail();
    run_verify(1'b1, "vfail");
    n_checks++; if (error !== 1'b1 || cpu_enable !== 1'b0 || done !== 1'b0 || dbg_state !== ST_ERROR) begin n_fail++; $display("FAIL vfail_end: got err=%b en=%b done=%b state=%0d expected 1 0 0 5", error, cpu_enable, done, dbg_state); end
    step();
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL vfail_hold: got err=%b expected 1", error); end
    do_abort();
    corrupt = 1'b0;
    n_checks++; if (error !== 1'b0 || dbg_state !== ST_IDLE || checksum !== 32'hDEAD_BEF0) begin n_fail++; $display("FAIL vfail_abort: got err=%b state=%0d cs=%h expected 0 0 deadbef0", error, dbg_state, checksum); end
  endtask

  task automatic test_zero_length();
    start_load(16'd0, 1'b0);
    n_checks++; if (dbg_state !== ST_RUN || done !== 1'b1 || cpu_enable !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_run: got state=%0d done=%b en=%b busy=%b expected 4 1 1 0", dbg_state, done, cpu_enable, busy); end
    start_load(16'd3, 1'b0);
    n_checks++; if (dbg_state !== ST_RUN || s_ready !== 1'b0) begin n_fail++; $display("FAIL run_ignores_start: got state=%0d rdy=%b expected 4 0", dbg_state, s_ready); end
    do_abort();
  endtask

  task automatic test_wrap();
    start_load(16'd2, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'h5;
    step();
    n_checks++; if (wr_wen !== 1'b1 || wr_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: got wen=%b addr=%h expected 1 fffffffffffffffc", wr_wen, wr_addr); end
    s_data  = 32'h6;
    step();
    s_valid = 1'b0;
    n_checks++; if (wr_wen !== 1'b1 || wr_addr !== 64'h0 || wr_checksum !== 32'hB) begin n_fail++; $display("FAIL wrap_second: got wen=%b addr=%h cs=%h expected 1 0 b", wr_wen, wr_addr, wr_checksum); end
    step();
    do_abort();
  endtask

  task automatic test_reset_mid_load();
    start_load(16'd4, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'hA1;
    step();
    s_valid = 1'b0;
    n_checks++; if (wen_ext !== 1'b1 || checksum !== 32'hA1) begin n_fail++; $display("FAIL midrst_pre: got wen=%b cs=%h expected 1 a1", wen_ext, checksum); end
    #1 arst = 1'b1;
    #1;
    n_checks++; if (wen_ext !== 1'b0 || s_ready !== 1'b0 || checksum !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got wen=%b rdy=%b cs=%h busy=%b expected 0 0 0 0", wen_ext, s_ready, checksum, busy); end
    #1 arst = 1'b0;
    step();
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midrst_idle: got state=%0d expected 0", dbg_state); end
    start_load(16'd2, 1'b0);
    n_checks++; if (dbg_state !== ST_LOAD) begin n_fail++; $display("FAIL midrst_restart: got state=%0d expected 1", dbg_state); end
    s_valid = 1'b1;
    s_data  = 32'hB2;
    step();
    n_checks++; if (wen_ext !== 1'b1 || addr_ext !== 64'h0 || wdata_ext !== 32'hB2) begin n_fail++; $display("FAIL midrst_w0: got wen=%b addr=%h data=%h expected 1 0 b2", wen_ext, addr_ext, wdata_ext); end
    s_data  = 32'hC3;
    step();
    s_valid = 1'b0;
    n_checks++; if (addr_ext !== 64'h4 || checksum !== 32'h175) begin n_fail++; $display("FAIL midrst_w1: got addr=%h cs=%h expected 4 175", addr_ext, checksum); end
    step();
    do_abort();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    arst      = 1'b1;
    start     = 1'b0;
    num_words = 16'd0;
    verify_en = 1'b0;
    abort     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    corrupt   = 1'b0;
    #1;
    test_reset();
    test_basic_load();
    test_gapped();
    test_verify_pass();
    test_verify_fail();
    test_zero_length();
    test_wrap();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
